i2c_bus_arbiter: RTL and testbench

- Shares one byte-level i2c_controller between NUM_REQ independent requesters, e.g. a sensor poller and a display-config engine inside main.
- Round-robin arbitration with one outstanding transaction at a time.
- Latches the winner's command and pulses the controller start.
- Waits for completion or timeout, then returns ACK/NACK, read data and timeout status to the winner only.

---
 rtl/i2c_bus_arbiter_pkg.sv | 15 +
 rtl/i2c_bus_arbiter_if.sv | 26 ++
 rtl/i2c_bus_arbiter_rr_arbiter.sv | 36 +++
 rtl/i2c_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding and the
// address/data widths of the byte-level i2c_controller command interface.
package i2c_bus_arbiter_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Command/completion interface between the arbiter and the i2c_controller.
//   master : arbiter side (drives ctrl_start/addr/rw/wdata)
//   slave  : controller side (drives ctrl_busy/done/ack/rdata)
interface i2c_bus_arbiter_if;
  import i2c_bus_arbiter_pkg::*;

  logic                  ctrl_start;
  logic [I2C_ADDR_W-1:0] ctrl_addr;
  logic                  ctrl_rw;
  logic [I2C_DATA_W-1:0] ctrl_wdata;
  logic                  ctrl_busy;
  logic                  ctrl_done;
  logic                  ctrl_ack;
  logic [I2C_DATA_W-1:0] ctrl_rdata;

  modport master (
    output ctrl_start, ctrl_addr, ctrl_rw, ctrl_wdata,
    input  ctrl_busy, ctrl_done, ctrl_ack, ctrl_rdata
  );

  modport slave (
    input  ctrl_start, ctrl_addr, ctrl_rw, ctrl_wdata,
    output ctrl_busy, ctrl_done, ctrl_ack, ctrl_rdata
  );

endinterface

// File: rtl/i2c_bus_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req        : request vector
//   last       : index of the most recently served requester
//   grant_next : one-hot winner (first set req scanning last+1, last+2, ...)
//   idx        : binary index of the winner
//   any        : at least one request is set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant_next,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned cand;

  // Scan ends on last itself, so a lone persistent requester is re-granted.
  always_comb begin
    grant_next = '0;
    idx        = '0;
    any        = 1'b0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last) + i) % NUM_REQ;
      if (!any && req[cand]) begin
        any              = 1'b1;
        idx              = IDX_W'(cand);
        grant_next[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one byte-level i2c_controller between NUM_REQ requesters.
// Round-robin arbitration, one outstanding transaction, command fields latched
// at grant, completion or timeout reported to the winner only.
//   clk, reset_bar          : clock, asynchronous active-low reset
//   req/req_addr/req_rw/req_wdata : per-requester command (packed slices)
//   grant, resp_valid       : one-hot owner and one-cycle completion pulse
//   resp_ack/timeout/rdata  : completion status, held until next capture
//   ctrl                    : command/completion interface to the controller
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           reset_bar,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_ack,
  output logic                           resp_timeout,
  output logic [I2C_DATA_W-1:0]          resp_rdata,
  i2c_bus_arbiter_if.master              ctrl
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                  resp_ack_q, resp_ack_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic [I2C_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                  ctrl_start_q, ctrl_start_d;
  logic [I2C_ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
  logic                  ctrl_rw_q, ctrl_rw_d;
  logic [I2C_DATA_W-1:0] ctrl_wdata_q, ctrl_wdata_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    rr_grant;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_any;

  logic [I2C_ADDR_W-1:0] slot_addr  [NUM_REQ];
  logic [I2C_DATA_W-1:0] slot_wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot_addr[g]  = req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
    assign slot_wdata[g] = req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last       (last_q),
    .grant_next (rr_grant),
    .idx        (rr_idx),
    .any        (rr_any)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    resp_valid_d   = '0;
    resp_ack_d     = resp_ack_q;
    resp_timeout_d = resp_timeout_q;
    resp_rdata_d   = resp_rdata_q;
    ctrl_start_d   = 1'b0;
    ctrl_addr_d    = ctrl_addr_q;
    ctrl_rw_d      = ctrl_rw_q;
    ctrl_wdata_d   = ctrl_wdata_q;
    win_d          = win_q;
    last_d         = last_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_any && !ctrl.ctrl_busy) begin
          grant_d      = rr_grant;
          win_d        = rr_idx;
          ctrl_addr_d  = slot_addr[rr_idx];
          ctrl_rw_d    = req_rw[rr_idx];
          ctrl_wdata_d = slot_wdata[rr_idx];
          // Registered start is high while the FSM sits in ISSUE.
          ctrl_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes precedence over a coincident expiry.
        if (ctrl.ctrl_done) begin
          resp_ack_d     = ctrl.ctrl_ack;
          resp_rdata_d   = ctrl.ctrl_rdata;
          resp_timeout_d = 1'b0;
          resp_valid_d   = grant_q;
          state_d        = ST_RESPOND;
        end else if (cnt_q == CNT_EXPIRE) begin
          resp_ack_d     = 1'b0;
          resp_rdata_d   = '0;
          resp_timeout_d = 1'b1;
          resp_valid_d   = grant_q;
          state_d        = ST_RESPOND;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        grant_d = '0;
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      resp_valid_q   <= '0;
      resp_ack_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= '0;
      ctrl_start_q   <= 1'b0;
      ctrl_addr_q    <= '0;
      ctrl_rw_q      <= 1'b0;
      ctrl_wdata_q   <= '0;
      win_q          <= '0;
      last_q         <= LAST_RST;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      resp_valid_q   <= resp_valid_d;
      resp_ack_q     <= resp_ack_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
      ctrl_start_q   <= ctrl_start_d;
      ctrl_addr_q    <= ctrl_addr_d;
      ctrl_rw_q      <= ctrl_rw_d;
      ctrl_wdata_q   <= ctrl_wdata_d;
      win_q          <= win_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
    end
  end

  assign grant           = grant_q;
  assign resp_valid      = resp_valid_q;
  assign resp_ack        = resp_ack_q;
  assign resp_timeout    = resp_timeout_q;
  assign resp_rdata      = resp_rdata_q;
  assign ctrl.ctrl_start = ctrl_start_q;
  assign ctrl.ctrl_addr  = ctrl_addr_q;
  assign ctrl.ctrl_rw    = ctrl_rw_q;
  assign ctrl.ctrl_wdata = ctrl_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: randomized requester rounds, a
// randomized controller stub, and a queue-based scoreboard.
module tb_i2c_bus_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned T = 16;

  typedef struct {
    int unsigned idx;
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  wdata;
  } grant_t;

  typedef struct {
    int unsigned idx;
    logic        ack;
    logic        to;
    logic [7:0]  rdata;
    longint      due;
  } resp_t;

  logic             clk = 1'b0;
  logic             reset_bar;
  logic [N-1:0]     req;
  logic [7*N-1:0]   req_addr;
  logic [N-1:0]     req_rw;
  logic [8*N-1:0]   req_wdata;
  logic [N-1:0]     grant;
  logic [N-1:0]     resp_valid;
  logic             resp_ack;
  logic             resp_timeout;
  logic [7:0]       resp_rdata;

  i2c_bus_arbiter_if ctrl_if ();

  i2c_bus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .reset_bar    (reset_bar),
    .req          (req),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_wdata    (req_wdata),
    .grant        (grant),
    .resp_valid   (resp_valid),
    .resp_ack     (resp_ack),
    .resp_timeout (resp_timeout),
    .resp_rdata   (resp_rdata),
    .ctrl         (ctrl_if)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  grant_t      exp_grant[$];
  int unsigned exp_owner[$];
  resp_t       exp_resp[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned mlast = N - 1;
  bit          stub_silent = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
  endtask

  // Controller stub: random done latency (including exact expiry, just after
  // expiry, and never), random ack/rdata, random busy.
  initial begin
    longint      done_at;
    logic        pa;
    logic [7:0]  prd;
    logic        busy_last;
    logic [N-1:0] gp;
    int unsigned d, sel, idx;
    resp_t       r;
    done_at = -1; pa = 1'b0; prd = '0; busy_last = 1'b0; gp = '0;
    ctrl_if.ctrl_done = 1'b0; ctrl_if.ctrl_ack = 1'b0;
    ctrl_if.ctrl_rdata = '0; ctrl_if.ctrl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_bar) begin
        done_at = -1; ctrl_if.ctrl_done = 1'b0; gp = '0;
        busy_last = 1'b0; ctrl_if.ctrl_busy = 1'b0;
        continue;
      end
      if (grant != '0 && gp == '0) check("busy_gate", busy_last, 1'b0);
      gp = grant;
      if (cyc == done_at) begin
        ctrl_if.ctrl_done = 1'b1; ctrl_if.ctrl_ack = pa; ctrl_if.ctrl_rdata = prd;
      end else begin
        ctrl_if.ctrl_done = 1'b0;
        ctrl_if.ctrl_ack = 1'($urandom_range(0, 1));
        ctrl_if.ctrl_rdata = 8'($urandom);
      end
      if (ctrl_if.ctrl_start) begin
        idx = (exp_owner.size() != 0) ? exp_owner.pop_front() : 0;
        sel = $urandom_range(0, 7);
        case (sel)
          0: d = T - 1;
          1: d = T;
          2: d = T + 1;
          3: d = 1000;
          default: d = $urandom_range(0, T - 2);
        endcase
        pa  = 1'($urandom_range(0, 1));
        prd = 8'($urandom);
        if (stub_silent) begin
          done_at = -1;
        end else begin
          done_at = (d <= T + 1) ? cyc + 1 + longint'(d) : -1;
          r.idx = idx;
          if (d <= T - 1) begin
            r.ack = pa; r.to = 1'b0; r.rdata = prd; r.due = cyc + 2 + longint'(d);
          end else begin
            r.ack = 1'b0; r.to = 1'b1; r.rdata = '0; r.due = cyc + 1 + longint'(T);
          end
          exp_resp.push_back(r);
        end
      end
      busy_last = ($urandom_range(0, 3) == 0);
      ctrl_if.ctrl_busy = busy_last;
    end
  end

  // Monitor: pops expectations whenever the DUT issues a start or a response.
  initial begin
    logic [N-1:0] gprev;
    logic [N-1:0] oh;
    logic         rise;
    grant_t       g;
    resp_t        r;
    gprev = '0;
    forever begin
      @(negedge clk);
      if (!reset_bar) begin
        gprev = '0;
        continue;
      end
      rise = (grant != '0) && (gprev == '0);
      if (rise || ctrl_if.ctrl_start) check("start_vs_grant", ctrl_if.ctrl_start, rise);
      if (ctrl_if.ctrl_start) begin
        if (exp_grant.size() == 0) begin
          miss("unexpected_start");
        end else begin
          g = exp_grant.pop_front();
          oh = '0; oh[g.idx] = 1'b1;
          check("grant", grant, oh);
          check("ctrl_addr", ctrl_if.ctrl_addr, g.addr);
          check("ctrl_rw", ctrl_if.ctrl_rw, g.rw);
          check("ctrl_wdata", ctrl_if.ctrl_wdata, g.wdata);
        end
      end
      if (resp_valid != '0) begin
        if (exp_resp.size() == 0) begin
          miss("unexpected_resp");
        end else begin
          r = exp_resp.pop_front();
          oh = '0; oh[r.idx] = 1'b1;
          check("resp_valid", resp_valid, oh);
          check("resp_ack", resp_ack, r.ack);
          check("resp_timeout", resp_timeout, r.to);
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_cycle", 32'(cyc), 32'(r.due));
        end
      end
      gprev = grant;
    end
  end

  // One round: each requester in mask performs 1..maxcnt transactions, keeping
  // req high between its own transactions. Service order comes from the
  // round-robin rule applied to the remaining-transaction counts.
  task automatic run_round(input logic [N-1:0] mask, input int unsigned maxcnt);
    logic [6:0]  fa [N][2];
    logic        fr [N][2];
    logic [7:0]  fw [N][2];
    int unsigned cnt [N];
    int unsigned rem [N];
    int unsigned nx [N];
    int unsigned served [N];
    bit          fin [N];
    bit          all_fin;
    logic [N-1:0] gprev;
    int unsigned total, budget, j;
    total = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cnt[k] = mask[k] ? $urandom_range(1, maxcnt) : 0;
      rem[k] = cnt[k]; nx[k] = 0; served[k] = 0; fin[k] = !mask[k];
      total += cnt[k];
      for (int unsigned n = 0; n < 2; n++) begin
        fa[k][n] = 7'($urandom); fr[k][n] = 1'($urandom); fw[k][n] = 8'($urandom);
      end
    end
    for (int unsigned t = 0; t < total; t++) begin
      for (int unsigned i = 1; i <= N; i++) begin
        j = (mlast + i) % N;
        if (rem[j] > 0) begin
          exp_grant.push_back('{idx: j, addr: fa[j][nx[j]], rw: fr[j][nx[j]], wdata: fw[j][nx[j]]});
          exp_owner.push_back(j);
          rem[j]--; nx[j]++; mlast = j;
          break;
        end
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (mask[k]) begin
        req_addr[7*k +: 7] = fa[k][0]; req_rw[k] = fr[k][0]; req_wdata[8*k +: 8] = fw[k][0];
      end
    end
    req = mask;
    gprev = grant;
    budget = 60 * total + 20;
    all_fin = 1'b0;
    while (!all_fin && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int unsigned k = 0; k < N; k++) begin
        if (grant[k] && !gprev[k]) begin
          served[k]++;
          if (served[k] < cnt[k]) begin
            req_addr[7*k +: 7] = fa[k][served[k]];
            req_rw[k] = fr[k][served[k]];
            req_wdata[8*k +: 8] = fw[k][served[k]];
          end else begin
            // Post-grant changes must not reach the latched command.
            req_addr[7*k +: 7] = 7'($urandom);
            req_rw[k] = 1'($urandom);
            req_wdata[8*k +: 8] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
          end
        end
        if (resp_valid[k] && served[k] >= cnt[k] && mask[k]) begin
          req[k] = 1'b0;
          fin[k] = 1'b1;
        end
      end
      gprev = grant;
      all_fin = 1'b1;
      for (int unsigned k = 0; k < N; k++) if (!fin[k]) all_fin = 1'b0;
    end
    if (!all_fin) begin
      miss("round_budget");
      req = '0;
    end
  endtask

  initial begin
    int unsigned wb;
    reset_bar = 1'b0;
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_resp_ack", resp_ack, 1'b0);
    check("rst_resp_timeout", resp_timeout, 1'b0);
    check("rst_resp_rdata", resp_rdata, 8'h00);
    check("rst_ctrl_start", ctrl_if.ctrl_start, 1'b0);
    check("rst_ctrl_addr", ctrl_if.ctrl_addr, 7'h00);
    check("rst_ctrl_wdata", ctrl_if.ctrl_wdata, 8'h00);
    reset_bar = 1'b1;
    repeat (2) @(negedge clk);

    run_round(3'b001, 1);
    run_round(3'b010, 1);
    run_round(3'b011, 2);
    run_round(3'b111, 2);
    for (int unsigned r = 0; r < 40; r++) begin
      run_round(N'($urandom_range(1, (1 << N) - 1)), 2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Reset while the controller is mid-transaction.
    repeat (3) @(negedge clk);
    stub_silent = 1'b1;
    req_addr[6:0] = 7'h3C; req_rw[0] = 1'b0; req_wdata[7:0] = 8'hA5;
    exp_grant.push_back('{idx: 0, addr: 7'h3C, rw: 1'b0, wdata: 8'hA5});
    exp_owner.push_back(0);
    req = 'b1;
    wb = 0;
    do begin
      @(negedge clk);
      wb++;
    end while (!ctrl_if.ctrl_start && wb < 100);
    if (!ctrl_if.ctrl_start) miss("reset_test_start");
    repeat (3) @(negedge clk);
    reset_bar = 1'b0;
    req = '0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_grant", grant, '0);
      check("midrst_ctrl_start", ctrl_if.ctrl_start, 1'b0);
      check("midrst_resp_valid", resp_valid, '0);
    end
    reset_bar = 1'b1;
    stub_silent = 1'b0;
    mlast = N - 1;
    repeat (T + 4) @(negedge clk);
    run_round(3'b011, 1);
    repeat (4) @(negedge clk);

    check("grant_queue_empty", 32'(exp_grant.size()), 0);
    check("resp_queue_empty", 32'(exp_resp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
